// File: rtl/micro_op_queue.sv
// Circular micro-op buffer between decode and execute: atomic group enqueue,
// head-justified multi-entry dequeue, flush on redirect, sticky protocol-error flag.
package DecoderTypes;
  typedef enum logic [3:0] {
    m_nop, m_ld, m_add, m_sub, m_st, m_br
  } uop_op_e;

  typedef struct packed {
    uop_op_e     opcode;
    logic [31:0] rip;
  } micro_op_t;
endpackage

// One dequeue lane: storage index of head+LANE and whether that slot is occupied.
module micro_op_queue_rd_lane #(
  parameter int DEPTH = 16,
  parameter int LANE  = 0,
  parameter int PW    = 4,
  parameter int CW    = 5
) (
  input  logic [PW-1:0] head_i,
  input  logic [CW-1:0] occ_i,
  output logic [PW-1:0] idx_o,
  output logic          vld_o
);
  logic [31:0] sum;

  always_comb begin
    sum   = 32'(head_i) + 32'(LANE);
    idx_o = (sum >= 32'(DEPTH)) ? PW'(sum - 32'(DEPTH)) : PW'(sum);
    vld_o = 32'(occ_i) > 32'(LANE);
  end
endmodule

module micro_op_queue
  import DecoderTypes::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int ENQ_WIDTH = 3,
  parameter  int DEQ_WIDTH = 2,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int EW        = $clog2(ENQ_WIDTH + 1),
  localparam int DW        = $clog2(DEQ_WIDTH + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           flush_i,
  input  logic                           enq_valid_i,
  input  logic [EW-1:0]                  enq_count_i,
  input  micro_op_t [ENQ_WIDTH-1:0]      enq_uops_i,
  output logic                           enq_ready_o,
  output micro_op_t [DEQ_WIDTH-1:0]      deq_uops_o,
  output logic [DEQ_WIDTH-1:0]           deq_valid_o,
  input  logic [DW-1:0]                  deq_take_i,
  output logic [CW-1:0]                  occupancy_o,
  output logic                           proto_err_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          err_q, err_d;
  micro_op_t     mem_q [DEPTH];

  logic          enq_fire, enq_bad, take_bad;
  logic [CW-1:0] enq_n, take_ext, eff_take;

  // Pointer advance that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input logic [31:0] n);
    logic [31:0] s;
    s = 32'(p) + n;
    return (s >= 32'(DEPTH)) ? PW'(s - 32'(DEPTH)) : PW'(s);
  endfunction

  assign enq_ready_o = (CW'(DEPTH) - occ_q) >= CW'(ENQ_WIDTH);
  assign occupancy_o = occ_q;
  assign proto_err_o = err_q;

  always_comb begin
    enq_fire = enq_valid_i & enq_ready_o & ~flush_i;
    enq_bad  = enq_fire & (32'(enq_count_i) > 32'(ENQ_WIDTH));
    enq_n    = (enq_fire & ~enq_bad) ? CW'(enq_count_i) : '0;
    take_ext = CW'(deq_take_i);
    take_bad = ~flush_i & (take_ext > occ_q);
    eff_take = take_bad ? occ_q : take_ext;
    err_d    = err_q | enq_bad | take_bad;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      head_d = wrap(head_q, 32'(eff_take));
      tail_d = wrap(tail_q, 32'(enq_n));
      occ_d  = occ_q + enq_n - eff_take;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      err_q  <= err_d;
    end
  end

  // Storage is not reset; only slots covered by the accepted group are written.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (CW'(i) < enq_n) mem_q[wrap(tail_q, 32'(i))] <= enq_uops_i[i];
      end
    end
  end

  for (genvar g = 0; g < DEQ_WIDTH; g++) begin : g_lane
    logic [PW-1:0] idx;
    micro_op_queue_rd_lane #(
      .DEPTH(DEPTH), .LANE(g), .PW(PW), .CW(CW)
    ) u_lane (
      .head_i(head_q),
      .occ_i (occ_q),
      .idx_o (idx),
      .vld_o (deq_valid_o[g])
    );
    assign deq_uops_o[g] = mem_q[idx];
  end

  a_occ_bound: assert property (@(posedge clk_i) disable iff (reset_i) 32'(occ_q) <= 32'(DEPTH));
  a_thermo: assert property (@(posedge clk_i) disable iff (reset_i)
    ((deq_valid_o + DEQ_WIDTH'(1)) & deq_valid_o) == '0);
  a_ptr_occ: assert property (@(posedge clk_i) disable iff (reset_i)
    (32'(occ_q) == 32'(DEPTH)) ? (head_q == tail_q)
      : (32'(occ_q) == (32'(tail_q) + 32'(DEPTH) - 32'(head_q)) % 32'(DEPTH)));
endmodule
